// File: rtl/act_skew_feeder.sv
// rtl/act_skew_feeder.sv - diagonal skew feeder for the systolic array left edge
module act_skew_feeder #(
    parameter int DATASIZE    = 8,
    parameter int ARRAYHEIGHT = 4,
    parameter int CNTW        = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [CNTW-1:0]                 num_vec,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [DATASIZE*ARRAYHEIGHT-1:0] in_act,
    output logic [DATASIZE*ARRAYHEIGHT-1:0] out_left_act,
    output logic [ARRAYHEIGHT-1:0]          out_act_valid,
    output logic                            busy,
    output logic                            done
);

    // Drain counter only needs to reach ARRAYHEIGHT-1; keep at least one bit.
    localparam int DW = (ARRAYHEIGHT > 1) ? $clog2(ARRAYHEIGHT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DRAIN
    } state_t;

    state_t          state;
    logic [CNTW-1:0] num_lat;
    logic [CNTW-1:0] cnt;
    logic [DW-1:0]   dcnt;
    logic            accept;

    // in_ready is a registered copy of "state is STREAM", so accept never
    // depends combinationally on anything but in_valid and flops.
    assign accept = in_valid & in_ready;

    // Job sequencer: latch length, count accepted beats, flush the skew, pulse done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            num_lat  <= '0;
            cnt      <= '0;
            dcnt     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (num_vec != '0) begin
                            num_lat  <= num_vec;
                            cnt      <= '0;
                            state    <= S_STREAM;
                            in_ready <= 1'b1;
                            busy     <= 1'b1;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                S_STREAM: begin
                    if (accept) begin
                        cnt <= cnt + CNTW'(1);
                        if (cnt + CNTW'(1) == num_lat) begin
                            state    <= S_DRAIN;
                            in_ready <= 1'b0;
                            dcnt     <= '0;
                        end
                    end
                end
                S_DRAIN: begin
                    // The last accepted element reaches the bottom row output on
                    // the ARRAYHEIGHT-th drain cycle; done follows right after.
                    if (dcnt == DW'(ARRAYHEIGHT - 1)) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        dcnt <= dcnt + DW'(1);
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

    for (genvar r = 0; r < ARRAYHEIGHT; r++) begin : g_row
        logic [DATASIZE-1:0] d_q [r+1];
        logic                v_q [r+1];

        // Row r delay line of r+1 stages; the head takes the accepted element
        // or a zero bubble every cycle so the diagonal skew never collapses.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int j = 0; j <= r; j++) begin
                    d_q[j] <= '0;
                    v_q[j] <= 1'b0;
                end
            end else begin
                d_q[0] <= accept ? in_act[r*DATASIZE +: DATASIZE] : '0;
                v_q[0] <= accept;
                for (int j = 1; j <= r; j++) begin
                    d_q[j] <= d_q[j-1];
                    v_q[j] <= v_q[j-1];
                end
            end
        end

        assign out_left_act[r*DATASIZE +: DATASIZE] = d_q[r];
        assign out_act_valid[r]                     = v_q[r];
    end

endmodule
